// File: rtl/level_update_engine_if.sv
// Command / memory-manager / response signal bundle for level_update_engine.
//   cmd_*  : order parser -> engine (valid/ready)
//   mem_*  : engine <-> memory_manager (start/valid, one request outstanding)
//   rsp_*  : engine -> consumer (valid/ready)
// Modport slave is the engine's view; master is the surrounding environment.
interface level_update_engine_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_qty;

  logic              mem_start;
  logic              mem_is_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_status;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_qty,
    output cmd_ready,
    output mem_start, mem_is_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_valid,
    output rsp_valid, rsp_data, rsp_status,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_qty,
    input  cmd_ready,
    input  mem_start, mem_is_write, mem_addr, mem_wdata,
    output mem_rdata, mem_valid,
    input  rsp_valid, rsp_data, rsp_status,
    output rsp_ready
  );
endinterface

// File: rtl/level_update_engine.sv
// Price-level read-modify-write engine in front of the order-book BRAM
// memory manager. QUERY reads a level; ADD/CANCEL read, saturate/clamp the
// quantity, write it back and report the resulting value plus status.
// Ports:
//   clk_in : clock
//   rst    : synchronous active-high reset (shared with memory manager)
//   bus    : level_update_engine_if.slave (cmd_*, mem_*, rsp_* groups)
// Optional feature macro LUE_TIMEOUT_EN: mem_valid watchdog of
// TIMEOUT_CYCLES cycles per wait state, reported as status 2 with data 0.
module level_update_engine #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_in,
  input  logic                  rst,
  level_update_engine_if.slave  bus
);

  localparam logic [1:0] OP_ADD    = 2'd1;
  localparam logic [1:0] OP_CANCEL = 2'd2;
  localparam logic [1:0] ST_OK     = 2'd0;
  localparam logic [1:0] ST_CLAMP  = 2'd1;
`ifdef LUE_TIMEOUT_EN
  localparam logic [1:0] ST_TMO    = 2'd2;
`endif

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, MODIFY, WR_ISSUE, WR_WAIT, RESP
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] qty_q, qty_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              mem_start_q, mem_start_d;
  logic              mem_is_write_q, mem_is_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_status_q, rsp_status_d;
  logic [DATA_W:0]   sum_c;

  // Extra top bit of the sum is the ADD carry used for saturation
  assign sum_c = {1'b0, rdata_q} + {1'b0, qty_q};

`ifdef LUE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit_c;

  // Watchdog counts cycles spent in a wait state; zero everywhere else
  always_comb begin
    tmo_d = '0;
    if (state_q == RD_WAIT || state_q == WR_WAIT) tmo_d = tmo_q + CNT_W'(1);
  end

  assign tmo_hit_c = (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  // State and output registers
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q        <= IDLE;
      op_q           <= '0;
      qty_q          <= '0;
      rdata_q        <= '0;
      cmd_ready_q    <= 1'b1;
      mem_start_q    <= 1'b0;
      mem_is_write_q <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_status_q   <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      qty_q          <= qty_d;
      rdata_q        <= rdata_d;
      cmd_ready_q    <= cmd_ready_d;
      mem_start_q    <= mem_start_d;
      mem_is_write_q <= mem_is_write_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_status_q   <= rsp_status_d;
    end
  end

  // Next-state and next-output logic; every output is set one cycle ahead
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    qty_d          = qty_q;
    rdata_d        = rdata_q;
    cmd_ready_d    = cmd_ready_q;
    mem_start_d    = 1'b0;
    mem_is_write_d = mem_is_write_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_data_d     = rsp_data_q;
    rsp_status_d   = rsp_status_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          op_d           = bus.cmd_op;
          qty_d          = bus.cmd_qty;
          mem_addr_d     = bus.cmd_addr;
          cmd_ready_d    = 1'b0;
          mem_start_d    = 1'b1;
          mem_is_write_d = 1'b0;
          state_d        = RD_ISSUE;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (bus.mem_valid) begin
          rdata_d = bus.mem_rdata;
          if (op_q == OP_ADD || op_q == OP_CANCEL) begin
            state_d = MODIFY;
          end else begin
            // QUERY and the reserved opcode respond with the stored value
            rsp_valid_d  = 1'b1;
            rsp_data_d   = bus.mem_rdata;
            rsp_status_d = ST_OK;
            state_d      = RESP;
          end
`ifdef LUE_TIMEOUT_EN
        end else if (tmo_hit_c) begin
          rsp_valid_d  = 1'b1;
          rsp_data_d   = '0;
          rsp_status_d = ST_TMO;
          state_d      = RESP;
`endif
        end
      end
      MODIFY: begin
        rsp_status_d = ST_OK;
        if (op_q == OP_ADD) begin
          if (sum_c[DATA_W]) begin
            mem_wdata_d  = '1;
            rsp_status_d = ST_CLAMP;
          end else begin
            mem_wdata_d = sum_c[DATA_W-1:0];
          end
        end else if (qty_q > rdata_q) begin
          mem_wdata_d  = '0;
          rsp_status_d = ST_CLAMP;
        end else begin
          mem_wdata_d = rdata_q - qty_q;
        end
        mem_start_d    = 1'b1;
        mem_is_write_d = 1'b1;
        state_d        = WR_ISSUE;
      end
      WR_ISSUE: state_d = WR_WAIT;
      WR_WAIT: begin
        if (bus.mem_valid) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = mem_wdata_q;
          state_d     = RESP;
`ifdef LUE_TIMEOUT_EN
        end else if (tmo_hit_c) begin
          rsp_valid_d  = 1'b1;
          rsp_data_d   = '0;
          rsp_status_d = ST_TMO;
          state_d      = RESP;
`endif
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.mem_start    = mem_start_q;
  assign bus.mem_is_write = mem_is_write_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_status   = rsp_status_q;

endmodule

// File: tb/tb_level_update_engine.sv
// Directed bench for level_update_engine with a latency-2, 256-word memory
// manager model that shares rst and clears its contents on reset.
module tb_level_update_engine;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned TMO    = 64;

  logic clk_in;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  level_update_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  level_update_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .bus   (bus.slave)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Memory manager model
  logic [31:0] mem [256];
  int          lat_cnt     = 0;
  int          start_cnt   = 0;
  int          wr_cnt      = 0;
  int          overlap_cnt = 0;
  logic [7:0]  p_addr;
  logic        p_wr;
  logic [31:0] p_wdata;
  logic        suppress = 1'b0;

  always @(posedge clk_in) begin
    bus.mem_valid <= 1'b0;
    if (rst) begin
      lat_cnt       <= 0;
      bus.mem_rdata <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (bus.mem_start) begin
      if (lat_cnt != 0) overlap_cnt <= overlap_cnt + 1;
      start_cnt <= start_cnt + 1;
      if (bus.mem_is_write) wr_cnt <= wr_cnt + 1;
      p_addr  <= bus.mem_addr;
      p_wr    <= bus.mem_is_write;
      p_wdata <= bus.mem_wdata;
      lat_cnt <= 2;
    end else if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1 && !suppress) begin
        bus.mem_valid <= 1'b1;
        bus.mem_rdata <= mem[p_addr];
        if (p_wr) mem[p_addr] <= p_wdata;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a command and return once it has been accepted (cmd_valid dropped)
  task automatic issue(input logic [1:0] op, input logic [7:0] addr, input logic [31:0] qty);
    int n;
    @(negedge clk_in);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_qty   = qty;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    chk("cmd_accept_wait", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk_in);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cycles);
    cycles = 0;
    while (!bus.rsp_valid && cycles < 500) begin
      @(negedge clk_in);
      cycles++;
    end
    chk("rsp_wait", 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    @(negedge clk_in);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] addr,
                         input logic [31:0] qty, input logic [31:0] exp_data,
                         input logic [1:0] exp_st, input int exp_starts, input int exp_wr);
    int s0, w0, cyc;
    s0 = start_cnt;
    w0 = wr_cnt;
    issue(op, addr, qty);
    wait_rsp(cyc);
    chk({tag, "_data"}, bus.rsp_data, exp_data);
    chk({tag, "_status"}, 32'(bus.rsp_status), 32'(exp_st));
    handshake();
    chk({tag, "_starts"}, 32'(start_cnt - s0), 32'(exp_starts));
    chk({tag, "_writes"}, 32'(wr_cnt - w0), 32'(exp_wr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, s0, w0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_addr  = '0;
    bus.cmd_qty   = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);

    // Reset state
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_mem_start", 32'(bus.mem_start), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_status", 32'(bus.rsp_status), 32'd0);

    // Basic read-modify-write sequence on level 5
    run_cmd("query0", 2'd0, 8'd5, 32'd0, 32'd0, 2'd0, 1, 0);
    run_cmd("add100", 2'd1, 8'd5, 32'd100, 32'd100, 2'd0, 2, 1);
    run_cmd("add50", 2'd1, 8'd5, 32'd50, 32'd150, 2'd0, 2, 1);
    chk("mem5_150", mem[5], 32'd150);
    run_cmd("cancel_under", 2'd2, 8'd5, 32'd200, 32'd0, 2'd1, 2, 1);
    chk("mem5_0", mem[5], 32'd0);
    run_cmd("add20", 2'd1, 8'd5, 32'h20, 32'h20, 2'd0, 2, 1);
    run_cmd("add_sat", 2'd1, 8'd5, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 2'd1, 2, 1);
    chk("mem5_sat", mem[5], 32'hFFFF_FFFF);
    run_cmd("cancel_f", 2'd2, 8'd5, 32'hF, 32'hFFFF_FFF0, 2'd0, 2, 1);
    run_cmd("op3_query", 2'd3, 8'd5, 32'd7, 32'hFFFF_FFF0, 2'd0, 1, 0);

    // Response back-pressure with a second command held by the source
    issue(2'd0, 8'd5, 32'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd1;
    bus.cmd_addr  = 8'd7;
    bus.cmd_qty   = 32'd3;
    wait_rsp(cyc);
    s0 = start_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rsp_data", bus.rsp_data, 32'hFFFF_FFF0);
      chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    chk("hold_no_start", 32'(start_cnt - s0), 32'd0);
    handshake();
    chk("post_hs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("post_hs_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk_in);
    bus.cmd_valid = 1'b0;
    chk("held_cmd_taken", 32'(bus.cmd_ready), 32'd0);
    wait_rsp(cyc);
    chk("held_add_data", bus.rsp_data, 32'd3);
    chk("held_add_status", 32'(bus.rsp_status), 32'd0);
    handshake();
    run_cmd("cancel_exact", 2'd2, 8'd7, 32'd3, 32'd0, 2'd0, 2, 1);

    // Reset while waiting for the write completion
    issue(2'd1, 8'd9, 32'd1);
    cyc = 0;
    while (!(bus.mem_start && bus.mem_is_write) && cyc < 100) begin
      @(negedge clk_in);
      cyc++;
    end
    chk("wr_start_seen", 32'(bus.mem_start && bus.mem_is_write), 32'd1);
    @(negedge clk_in);
    rst = 1'b1;
    @(negedge clk_in);
    rst = 1'b0;
    chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_mem_start", 32'(bus.mem_start), 32'd0);
    w0 = wr_cnt;
    repeat (5) @(negedge clk_in);
    chk("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_no_write", 32'(wr_cnt - w0), 32'd0);
    run_cmd("post_rst_query", 2'd0, 8'd9, 32'd0, 32'd0, 2'd0, 1, 0);

`ifdef LUE_TIMEOUT_EN
    // Watchdog on a read that never completes
    suppress = 1'b1;
    issue(2'd1, 8'd5, 32'd4);
    wait_rsp(cyc);
    chk("tmo_status", 32'(bus.rsp_status), 32'd2);
    chk("tmo_data", bus.rsp_data, 32'd0);
    chk("tmo_latency_min", 32'(cyc >= int'(TMO) - 1), 32'd1);
    w0 = wr_cnt;
    handshake();
    suppress = 1'b0;
    repeat (4) @(negedge clk_in);
    chk("tmo_no_write", 32'(wr_cnt - w0), 32'd0);
    run_cmd("tmo_recover", 2'd0, 8'd3, 32'd0, 32'd0, 2'd0, 1, 0);
`endif

    chk("no_overlap", 32'(overlap_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
